// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon 128/128 key schedule.
package simon_pkg;

  localparam int SIMON_WORD   = 64;
  localparam int SIMON_ROUNDS = 68;
  localparam int SIMON_Z_LEN  = 62;

  // z2 constant sequence, indexed LSB-first (bit 0 is z2[0]).
  localparam logic [61:0] SIMON_Z2 = 62'h3369_F885_192C_0EF5;

  // ~3 in 64 bits; folds the bitwise inversion of k[i] and the constant 3 into one XOR.
  localparam logic [SIMON_WORD-1:0] SIMON_C = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ks_state_t;

  // Select one bit of z2. The table is padded to 64 entries so that every
  // 6-bit index is in range; entries 62 and 63 are never used.
  function automatic logic z2_bit(input logic [5:0] idx);
    logic [63:0] z2_ext;
    z2_ext = {2'b00, SIMON_Z2};
    return z2_ext[idx];
  endfunction

endpackage

// File: rtl/simon_ks_step.sv
// One step of the Simon m=2 key recurrence:
// k[i+2] = C ^ z ^ k[i] ^ ROR(k[i+1],3) ^ ROR(k[i+1],4).
module simon_ks_step
  import simon_pkg::*;
(
  input  logic [63:0] ka_i,
  input  logic [63:0] kb_i,
  input  logic        z_i,
  output logic [63:0] kb_next_o
);

  logic [SIMON_WORD-1:0] ror3;
  logic [SIMON_WORD-1:0] ror4;

  // Pure XOR/rotate network; there is no carry logic.
  always_comb begin
    ror3      = {kb_i[2:0], kb_i[63:3]};
    ror4      = {kb_i[3:0], kb_i[63:4]};
    kb_next_o = SIMON_C ^ {63'd0, z_i} ^ ka_i ^ ror3 ^ ror4;
  end

endmodule

// File: rtl/simon_key_schedule.sv
// Sequential Simon 128/128 round-key generator. It expands a 128-bit master
// key and streams k[0]..k[ROUNDS-1] over a valid/ready handshake.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic [63:0]  kj_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic [6:0]   round_o,
  output logic         last_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);
  localparam logic [5:0] ZI_MAX   = 6'(SIMON_Z_LEN - 1);

  ks_state_t             state_q, state_d;
  logic [SIMON_WORD-1:0] ka_q, ka_d;
  logic [SIMON_WORD-1:0] kb_q, kb_d;
  logic [6:0]            rnd_q, rnd_d;
  logic [5:0]            zi_q, zi_d;
  logic [SIMON_WORD-1:0] kb_step;
  logic                  z_bit;
  logic                  hs;

  assign z_bit = z2_bit(zi_q);

  simon_ks_step u_step (
    .ka_i      (ka_q),
    .kb_i      (kb_q),
    .z_i       (z_bit),
    .kb_next_o (kb_step)
  );

  // Next-state logic: load on start, shift the key window on every handshake.
  // The kb values computed for the final two rounds are never shown, so they are not gated.
  always_comb begin
    state_d = state_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    rnd_d   = rnd_q;
    zi_d    = zi_q;
    hs      = (state_q == RUN) && key_ready_i;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          ka_d    = key_i[63:0];
          kb_d    = key_i[127:64];
          rnd_d   = 7'd0;
          zi_d    = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (rnd_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            ka_d  = kb_q;
            kb_d  = kb_step;
            rnd_d = rnd_q + 7'd1;
            zi_d  = (zi_q == ZI_MAX) ? 6'd0 : zi_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and key registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ka_q    <= '0;
      kb_q    <= '0;
      rnd_q   <= '0;
      zi_q    <= '0;
    end else begin
      state_q <= state_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      rnd_q   <= rnd_d;
      zi_q    <= zi_d;
    end
  end

  // Outputs decode registers only; key_ready_i never reaches them combinationally.
  assign kj_o        = ka_q;
  assign round_o     = rnd_q;
  assign key_valid_o = (state_q == RUN);
  assign last_o      = (state_q == RUN) && (rnd_q == LAST_RND);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_simon_key_schedule.sv
// Bench for simon_key_schedule: scoreboard of expected round keys fed from a
// reference model of the Simon 128/128 key expansion, with a separate monitor.
module tb_simon_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [127:0] key_i;
  logic [63:0]  kj_o;
  logic         key_valid_o;
  logic         key_ready_i;
  logic [6:0]   round_o;
  logic         last_o;
  logic         busy_o;
  logic         done_o;

  simon_key_schedule #(.ROUNDS(68)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .key_i       (key_i),
    .kj_o        (kj_o),
    .key_valid_o (key_valid_o),
    .key_ready_i (key_ready_i),
    .round_o     (round_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_k[$];
  logic [6:0]  exp_r[$];
  logic [63:0] cap[$];
  logic [63:0] kat_keys[$];
  logic [63:0] mk[68];
  int          xfers;
  int          dones;
  bit          done_expect = 1'b0;
  bit          prev_stall  = 1'b0;
  logic [72:0] prev_out;
  bit          bp_mode = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // Reference key expansion in the textbook form: tmp = S^-3 k[i+1]; tmp ^= S^-1 tmp;
  // k[i+2] = ~k[i] ^ tmp ^ z2[i mod 62] ^ 3.
  task automatic build_model(input logic [127:0] key);
    logic [63:0] tmp;
    logic [61:0] z;
    z = 62'h3369_F885_192C_0EF5;
    mk[0] = key[63:0];
    mk[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      tmp = ror64(mk[i+1], 3);
      tmp = tmp ^ ror64(tmp, 1);
      mk[i+2] = ~mk[i] ^ tmp ^ {63'd0, z[i % 62]} ^ 64'd3;
    end
  endtask

  task automatic push_expected(input logic [127:0] key);
    build_model(key);
    for (int i = 0; i < 68; i++) begin
      exp_k.push_back(mk[i]);
      exp_r.push_back(7'(i));
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {kj_o, round_o, key_valid_o, last_o, busy_o, done_o}, 128'd0);
  endtask

  // Ready driver: always high, or a fair coin per cycle under backpressure.
  initial begin
    key_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      key_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold/done behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_expect = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (done_expect) begin
        chk("done_after_last", done_o, 1);
        done_expect = 1'b0;
      end
      if (done_o) dones++;
      if (prev_stall)
        chk("hold_under_stall", {key_valid_o, last_o, round_o, kj_o}, prev_out);
      if (key_valid_o && key_ready_i) begin
        xfers++;
        if (exp_k.size() == 0) begin
          chk("unexpected_transfer", exp_k.size(), 1);
        end else begin
          logic [63:0] e;
          logic [6:0]  r;
          e = exp_k.pop_front();
          r = exp_r.pop_front();
          chk("key_last_round", {last_o, round_o, kj_o}, {r == 7'd67, r, e});
          cap.push_back(kj_o);
          if (r == 7'd67) done_expect = 1'b1;
        end
      end
      prev_stall = key_valid_o && !key_ready_i;
      prev_out   = {key_valid_o, last_o, round_o, kj_o};
    end
  end

  task automatic run_expansion(input logic [127:0] key, input bit bp, input bit inject,
                               input bit check_lat);
    int cyc;
    bit seen;
    int busy_bad;
    push_expected(key);
    cap.delete();
    xfers    = 0;
    dones    = 0;
    bp_mode  = bp;
    busy_bad = 0;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    key_i   = key;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    key_i   = ~key;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == 5) begin
        start_i = 1'b1;
        key_i   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start_i = 1'b0;
      end
      if (done_o) seen = 1'b1;
      else if (!busy_o) busy_bad++;
    end
    start_i = 1'b0;
    chk("done_seen", seen, 1);
    if (check_lat) chk("done_latency", cyc, 69);
    chk("busy_through_run", busy_bad, 0);
    repeat (2) @(negedge clk);
    chk("transfer_count", xfers, 68);
    chk("done_pulse_count", dones, 1);
    chk("scoreboard_drained", exp_k.size(), 0);
    chk("idle_after_done", {busy_o, key_valid_o, done_o}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt, ct;
    logic [63:0]  x, y, t;
    int           diffs;
    bit           found;
    rst_n   = 1'b0;
    start_i = 1'b0;
    key_i   = '0;

    // Reset state, then idle with start low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_zero("idle_hold");
    end

    // Known-answer run with ready held high.
    run_expansion(128'h0f0e0d0c0b0a0908_0706050403020100, 1'b0, 1'b0, 1'b1);
    kat_keys = cap;
    if (cap.size() == 68) begin
      chk("kat_k0", cap[0], 64'h0706050403020100);
      chk("kat_k1", cap[1], 64'h0f0e0d0c0b0a0908);
      pt = 128'h6373656420737265_6c6c657661727420;
      x  = pt[127:64];
      y  = pt[63:0];
      for (int i = 0; i < 68; i++) begin
        t = x;
        x = y ^ ((rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2)) ^ cap[i];
        y = t;
      end
      ct = {x, y};
      chk("kat_ciphertext", ct, 128'h49681b1e1e54fe3f_65aa832af84e0bbc);
    end else begin
      chk("kat_key_count", cap.size(), 68);
    end

    // Same key under random backpressure, with a stray start mid-run.
    run_expansion(128'h0f0e0d0c0b0a0908_0706050403020100, 1'b1, 1'b1, 1'b0);
    diffs = 0;
    if (cap.size() == 68 && kat_keys.size() == 68) begin
      for (int i = 0; i < 68; i++) if (cap[i] !== kat_keys[i]) diffs++;
    end else begin
      diffs = -1;
    end
    chk("bp_matches_kat", diffs, 0);

    // Random keys, backpressure.
    for (int r = 0; r < 3; r++)
      run_expansion({$urandom, $urandom, $urandom, $urandom}, 1'b1, r[0], 1'b0);

    // Reset in the middle of an expansion.
    push_expected({$urandom, $urandom, $urandom, $urandom});
    bp_mode = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    key_i   = {$urandom, $urandom, $urandom, $urandom};
    build_model(key_i);
    exp_k.delete();
    exp_r.delete();
    for (int i = 0; i < 68; i++) begin
      exp_k.push_back(mk[i]);
      exp_r.push_back(7'(i));
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (key_valid_o && round_o == 7'd30) found = 1'b1;
    end
    chk("reach_round30", found, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_clear");
    exp_k.delete();
    exp_r.delete();
    @(negedge clk);
    chk_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_expansion({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simon_key_schedule.md
# simon_key_schedule

Sequential round-key generator for Simon 128/128 (64-bit words, m = 2, T = 68 rounds, constant sequence z2). It expands a 128-bit master key into the 68 round keys k[0]..k[67] and streams them one per accepted handshake. It sits directly upstream of the Simon round stage and drives that stage's 64-bit `kj_i` input. Round i of the datapath consumes k[i] in strict order.

## Interface
Parameters:
- `ROUNDS`, 68: number of round keys emitted per expansion. Fixed for Simon 128/128. Other values are out of scope.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start_i`, input, 1: one-cycle request to begin an expansion. Sampled only in IDLE.
- `key_i`, input, 128: master key, sampled with `start_i`. `key_i[63:0]` = k[0], `key_i[127:64]` = k[1].
- `kj_o`, output, 64: current round key k[round_o].
- `key_valid_o`, output, 1: `kj_o` is valid.
- `key_ready_i`, input, 1: consumer accepts `kj_o`. The transfer happens when valid and ready are both high.
- `round_o`, output, 7: index of the key on `kj_o` (0..67).
- `last_o`, output, 1: high with `key_valid_o` when `round_o` = 67.
- `busy_o`, output, 1: high whenever the state is not IDLE.
- `done_o`, output, 1: one-cycle pulse in the cycle after k[67] is accepted.

## Operation
- State registers: `ka`, which holds k[i] and is what `kj_o` shows, and `kb`, which holds k[i+1]. Also a 7-bit round counter `rnd` and a 6-bit z-index `zi`.
- States:
  - IDLE: waiting for a start.
  - RUN: streaming keys.
  - DONE: a single cycle that asserts `done_o`, then returns to IDLE.
- IDLE, `start_i` = 1:
  - `ka` <= key_i[63:0], `kb` <= key_i[127:64].
  - `rnd` <= 0, `zi` <= 0.
  - Go to RUN.
- IDLE, `start_i` = 0: registers hold.
- RUN:
  - `key_valid_o` = 1.
  - On a handshake with `rnd` < 67:
    - `ka` <= `kb`.
    - `kb` <= `C` ^ z2[`zi`] ^ `ka` ^ ROR(`kb`,3) ^ ROR(`kb`,4), where `C` = 64'hFFFF_FFFF_FFFF_FFFC and z2[`zi`] sits at bit 0.
    - `rnd` increments by 1.
    - `zi` <= (`zi` == 61) ? 0 : `zi` + 1.
  - On a handshake with `rnd` = 67: go to DONE.
  - With no handshake, all registers hold and `kj_o` stays stable.
- Computing `kb` for rounds ≥ 66 produces unused values. This is harmless and needs no gating.
- z2 is the 62-bit constant 62'h3369_F885_192C_0EF5, indexed LSB-first. Bit 0 of the constant is z2[0] = 1.
- `zi` wraps at 62. The bench must exercise this wrap, which first occurs at generated key k[64].
- All arithmetic is 64-bit XOR and rotate only. There is no carry logic.
- `start_i` is ignored in RUN and DONE. There is no abort; a new expansion requires a return to IDLE.
- `ka`, `kb` and `zi` update only on a handshake.

## Timing
- Reset values:
  - `kj_o` = 0, `key_valid_o` = 0, `round_o` = 0.
  - `last_o` = 0, `busy_o` = 0, `done_o` = 0.
  - State = IDLE.
- Reset asserted mid-expansion clears everything immediately (asynchronously). No further keys are emitted.
- Latency:
  - `start_i` at cycle n gives `key_valid_o` and k[0] at cycle n+1.
  - With `key_ready_i` held high, one key is emitted per cycle. k[67] appears at n+68 and `done_o` at n+69.
  - `busy_o` is high from n+1 through n+69 inclusive.
- All outputs are registered or decoded directly from state and registers. There is no combinational path from `key_ready_i` to `kj_o` or `key_valid_o`.
- Under backpressure, `kj_o`, `round_o` and `last_o` hold until accepted. `key_valid_o` never drops before the handshake.

## Structure
- A shared package `simon_pkg` holds:
  - `SIMON_WORD` = 64.
  - `SIMON_ROUNDS` = 68.
  - `SIMON_Z2` (62 bits).
  - `SIMON_C` = 64'hFFFF_FFFF_FFFF_FFFC.
  - A `ks_state_t` enum {IDLE, RUN, DONE}.
- One natural sub-module: `simon_ks_step`. It is combinational and computes next `kb` from `ka`, `kb` and z-bit.
- Everything else lives in this module.

## Test plan
- Reset then idle: with `start_i` low, hold for 10 cycles. All outputs stay 0.
- Known-answer test:
  - Stimulus: key = 128'h0f0e0d0c0b0a0908_0706050403020100, ready held high.
  - Required keys: k[0] = 64'h0706050403020100, k[1] = 64'h0f0e0d0c0b0a0908.
  - Remaining keys must match a software model.
  - Feeding all 68 keys into the round stage with plaintext 128'h6373656420737265_6c6c657661727420 must give 128'h49681b1e1e54fe3f_65aa832af84e0bbc.
- Random backpressure: toggle `key_ready_i` at 50%.
  - The key sequence must be identical to the known-answer run.
  - `kj_o` must be stable while valid and not ready.
  - Exactly 68 transfers must occur.
- Boundary:
  - `last_o` is high only with `round_o` = 67.
  - `done_o` pulses exactly once, one cycle after the last transfer.
  - k[64] and later keys are correct, which checks the `zi` wrap.
- `start_i` asserted in RUN with a different key is ignored: the sequence is unchanged.
- `rst_n` pulsed at `round_o` = 30: outputs clear at once. A fresh `start_i` restarts cleanly from k[0].
